// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - EX-stage command and HI/LO result bundle for the multiply/divide unit
interface mdu_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             cancel;
  logic             isbusy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, cancel,
    input  isbusy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, cancel,
    output isbusy, done, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative shift-add multiply / restoring divide sequencer owning HI/LO
module mdu_ctrl #(
  parameter int ITER  = 32,
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_ctrl_if.slave  bus
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic [WIDTH-1:0]     rs_keep;
  logic                 is_div;
  logic                 div0;
  logic                 sign_q;
  logic                 sign_r;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q;

  logic                 issue, arith_issue, mthi, mtlo, is_signed;
  logic [WIDTH-1:0]     abs_rs, abs_rt;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic                 div_ge;
  logic [WIDTH-1:0]     rem_sub;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  always_comb begin
    issue       = (state == S_IDLE) && bus.start && !bus.cancel;
    arith_issue = issue && !bus.op[2];
    mthi        = issue && (bus.op == 3'b100);
    mtlo        = issue && (bus.op == 3'b101);
    is_signed   = !bus.op[0];
    abs_rs      = (is_signed && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    abs_rt      = (is_signed && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
  end

  // Stall must cover the issue cycle itself, so the command decode feeds isbusy directly.
  assign bus.isbusy = (state != S_IDLE) || (bus.start && !bus.cancel && !bus.op[2]);
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, quotient}; the shifted-in remainder is WIDTH+1 bits wide.
    div_ge   = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd};
    rem_sub  = acc[2*WIDTH-2:WIDTH-1] - opnd;
    div_next = div_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod_fix = sign_q ? -acc : acc;
    quot_fix = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (div0) begin
      fix_hi = rs_keep;
      fix_lo = {WIDTH{1'b1}};
    end else begin
      fix_hi = rem_fix;
      fix_lo = quot_fix;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (arith_issue) state_d = S_CALC;
      S_CALC:  if (cnt == LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.cancel) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      rs_keep <= '0;
      is_div  <= 1'b0;
      div0    <= 1'b0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (arith_issue) begin
            is_div  <= bus.op[1];
            div0    <= bus.op[1] && (bus.rt_data == '0);
            rs_keep <= bus.rs_data;
            sign_q  <= is_signed && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
            sign_r  <= is_signed && bus.rs_data[WIDTH-1];
            if (bus.op[1]) begin
              acc  <= {{WIDTH{1'b0}}, abs_rs};
              opnd <= abs_rt;
            end else begin
              acc  <= {{WIDTH{1'b0}}, abs_rt};
              opnd <= abs_rs;
            end
          end
          if (mthi) hi_q <= bus.rs_data;
          if (mtlo) lo_q <= bus.rs_data;
        end
        S_CALC: begin
          if (!bus.cancel) begin
            cnt <= cnt + 1'b1;
            acc <= is_div ? div_next : mul_next;
          end
        end
        S_FIX: begin
          if (!bus.cancel) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - vector table, random model comparison and corner sequences for mdu_ctrl
module tb_mdu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_ctrl_if #(.WIDTH(32)) bus();

  mdu_ctrl #(.ITER(32), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results from plain integer arithmetic on the operand values.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      3'd0: p = sa * sb;
      3'd1: p = {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
      default: p = {cur_hi, cur_lo};
    endcase
    return p;
  endfunction

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int done_at, done_n, busy_n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b; bus.cancel = 1'b0;
    #1;
    busy_n = bus.isbusy ? 1 : 0;
    done_at = 0;
    done_n  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      #1;
      if (bus.isbusy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
    end
    chk({name, " done_cycle"}, 64'(done_at), 64'd34);
    chk({name, " done_count"}, 64'(done_n), 64'd1);
    chk({name, " busy_cycles"}, 64'(busy_n), 64'd34);
    chk({name, " hi"}, {32'b0, bus.hi}, {32'b0, eh});
    chk({name, " lo"}, {32'b0, bus.lo}, {32'b0, el});
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] m;
    int          dn;

    bus.start = 1'b0; bus.op = '0; bus.rs_data = '0; bus.rt_data = '0; bus.cancel = 1'b0;

    tbl[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1] = '{3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[5] = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    tbl[7] = '{3'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
    tbl[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    #1;
    chk("reset hi", {32'b0, bus.hi}, 64'd0);
    chk("reset lo", {32'b0, bus.lo}, 64'd0);
    chk("reset isbusy", {63'b0, bus.isbusy}, 64'd0);
    chk("reset done", {63'b0, bus.done}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 5));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      m = model(ro, ra, rb);
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, m[63:32], m[31:0]);
    end

    // MTHI then MTLO on consecutive edges: immediate, never busy, no done.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.rs_data = 32'h1234_5678;
    #1 chk("mthi isbusy", {63'b0, bus.isbusy}, 64'd0);
    @(negedge clk);
    chk("mthi hi", {32'b0, bus.hi}, 64'h1234_5678);
    chk("mthi lo kept", {32'b0, bus.lo}, {32'b0, cur_lo});
    chk("mthi done", {63'b0, bus.done}, 64'd0);
    bus.op = 3'b101; bus.rs_data = 32'hCAFE_F00D;
    #1 chk("mtlo isbusy", {63'b0, bus.isbusy}, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("mtlo lo", {32'b0, bus.lo}, 64'hCAFE_F00D);
    chk("mtlo hi kept", {32'b0, bus.hi}, 64'h1234_5678);
    chk("mtlo done", {63'b0, bus.done}, 64'd0);
    chk("mtlo isbusy after", {63'b0, bus.isbusy}, 64'd0);
    cur_hi = 32'h1234_5678;
    cur_lo = 32'hCAFE_F00D;

    // Reserved op has no effect.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b110; bus.rs_data = 32'hDEAD_BEEF;
    #1 chk("rsvd isbusy", {63'b0, bus.isbusy}, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("rsvd hi", {32'b0, bus.hi}, {32'b0, cur_hi});
    chk("rsvd lo", {32'b0, bus.lo}, {32'b0, cur_lo});

    // DIV cancelled around iteration 10.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.rs_data = 32'd1000; bus.rt_data = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    #1 chk("cancel isbusy", {63'b0, bus.isbusy}, 64'd0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1 if (bus.done) dn++;
    end
    chk("cancel done_count", 64'(dn), 64'd0);
    chk("cancel hi", {32'b0, bus.hi}, {32'b0, cur_hi});
    chk("cancel lo", {32'b0, bus.lo}, {32'b0, cur_lo});

    // start with cancel in the same cycle: arithmetic op and MTHI both suppressed.
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 3'd1; bus.rs_data = 32'd5; bus.rt_data = 32'd9;
    #1 chk("start+cancel isbusy", {63'b0, bus.isbusy}, 64'd0);
    @(negedge clk);
    bus.op = 3'b100; bus.rs_data = 32'h5555_AAAA;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    #1;
    chk("start+cancel busy after", {63'b0, bus.isbusy}, 64'd0);
    chk("start+cancel hi", {32'b0, bus.hi}, {32'b0, cur_hi});
    chk("start+cancel lo", {32'b0, bus.lo}, {32'b0, cur_lo});

    // Asynchronous reset mid-CALC, checked before any further rising edge.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.rs_data = 32'h0001_2345; bus.rt_data = 32'h000A_BCDE;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst hi", {32'b0, bus.hi}, 64'd0);
    chk("async rst lo", {32'b0, bus.lo}, 64'd0);
    chk("async rst isbusy", {63'b0, bus.isbusy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    run_op("post-rst multu", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
